// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the multi-port register file.
// The master drives the read addresses and the write port.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic                   we;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   clr_busy;
  logic                   wr_drop;

  modport master (
    output rd_addr, we, wr_addr, wr_data,
    input  rd_data, clr_busy, wr_drop
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data,
    output rd_data, clr_busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired zero register,
// write-to-read bypass and a sequential post-reset clear engine.
module regfile_mp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int N_RD        = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int RESET_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   clr_cnt_q;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_to_zero;
  logic [N_RD*DATA_W-1:0] rd_data_c;

  // Clear sequencer and drop flag; memory itself is untouched by the reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (RESET_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          wr_drop_q <= bus.we;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          wr_drop_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_RUN;
          wr_drop_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_to_zero = (ZERO_REG != 0) && (bus.wr_addr == {ADDR_W{1'b0}});

  // Select the single memory write per cycle: clear engine wins over the port
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (rst) begin
      mem_we = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[ADDR_W-1:0];
    end else if (bus.we && !wr_to_zero) begin
      mem_we    = 1'b1;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Register array storage
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Per-port read mux: busy, then zero register, then bypass, then storage
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (state_q == ST_CLEAR) begin
        rd_data_c[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (bus.rd_addr[k*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
        rd_data_c[k*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && bus.we &&
                   (bus.wr_addr == bus.rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
      end else begin
        rd_data_c[k*DATA_W +: DATA_W] = mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.clr_busy = (state_q == ST_CLEAR);
  assign bus.wr_drop  = wr_drop_q;
endmodule
